lsm_moment_accum: RTL and testbench
===================================

LSM_MOMENT_ACCUM -- requirements
Module: lsm_moment_accum

Interface
REQ-001 Parameter WIDTH, default fpga_cfg_pkg::FP_WIDTH, is the signed fixed-point sample width.
REQ-002 Parameter QFRAC, default fpga_cfg_pkg::FP_QFRAC, is the number of fraction bits.
REQ-003 Parameter ACC_W, default fpga_cfg_pkg::ACC_WIDTH, is the accumulator width; ACC_W SHALL be >= 2*WIDTH-QFRAC+8.
REQ-004 Port clk, input, 1 bit: the single clock.
REQ-005 Port rst_n, input, 1 bit: synchronous active-low reset.
REQ-006 Port start, input, 1 bit: begins a regression batch.
REQ-007 Port n_paths, input, 16 bits: number of samples in the batch, sampled on start.
REQ-008 Port valid_in, input, 1 bit, and ready_out, output, 1 bit: the sample handshake.
REQ-009 Port S_t, input, WIDTH bits, signed: spot price.
REQ-010 Port Y, input, WIDTH bits, signed: discounted realised future cashflow.
REQ-011 Port strike, input, WIDTH bits, signed: strike price.
REQ-012 Port valid_out, output, 1 bit, and ready_in, input, 1 bit: the result handshake.
REQ-013 Port m, output, ACC_W bits x5: m[k] = sum of S^k over in-the-money (ITM) samples; m[0] is an integer count, m[1..4] are Q(QFRAC).
REQ-014 Port r, output, ACC_W bits x3: r[k] = sum of Y*S^k over ITM samples, Q(QFRAC).
REQ-015 Port ovf, output, 1 bit: sticky saturation flag for the batch.

Function
REQ-016 FSM states SHALL be IDLE, ACCUM, DRAIN and EMIT.
REQ-017 IDLE + start: clear the accumulators and ovf, load the remaining count from n_paths, and go to ACCUM; if n_paths==0, go directly to EMIT with all-zero results.
REQ-018 start outside IDLE SHALL be ignored.
REQ-019 ready_out SHALL be 1 only in ACCUM; a sample is accepted when valid_in && ready_out, at up to one per cycle, and each acceptance decrements the remaining count.
REQ-020 A sample is ITM iff strike > S_t; non-ITM samples are consumed but contribute nothing, and m[0] does not increment for them.
REQ-021 Products SHALL be computed as (a*b)>>>QFRAC (arithmetic shift, truncation), sign-extended to ACC_W: S2=S*S, S3=S2*S, S4=S2*S2, YS=Y*S, YS2=YS*S.
REQ-022 The product pipeline SHALL have fixed latency: stage 1 registers S2 and YS, stage 2 registers S3, S4 and YS2, stage 3 updates the accumulators; an accepted sample updates the accumulators exactly 3 cycles after acceptance.
REQ-023 When the last sample is accepted, the FSM SHALL go to DRAIN, stay 3 cycles until the pipeline is empty, then go to EMIT.
REQ-024 Accumulator adds SHALL saturate to the signed ACC_W limits; any saturation sets ovf until the next start.
REQ-025 In EMIT, valid_out=1 and m, r and ovf SHALL be held stable until ready_in; on valid_out && ready_in the FSM returns to IDLE and valid_out drops on the next cycle.
REQ-026 Outputs SHALL hold their last values in IDLE; the next start clears them.

Reset
REQ-027 On rst_n low at a clock edge: state=IDLE, valid_out=0, ready_out=0, m, r, ovf and the remaining count = 0, and all pipeline valid bits = 0, including when reset arrives mid-ACCUM or mid-EMIT.

Structure
REQ-028 ACC_WIDTH and a packed typedef moments_t (m[0:4], r[0:2], ovf) SHALL live in fpga_cfg_pkg; the FSM state enum SHALL be local to the module.
REQ-029 The product pipeline (REQ-021/022) SHALL be one sub-module, lsm_moment_pipe, with a valid bit per stage and no backpressure.

Verification (WIDTH=32, QFRAC=16, ACC_W=64)
REQ-030 Bench: n_paths=1, S=0x00010000, strike=0x00020000, Y=0x00008000 -> m={1,0x10000,0x10000,0x10000,0x10000}, r={0x8000,0x8000,0x8000}, ovf=0.
REQ-031 Bench: n_paths=2, one ITM sample as in REQ-030 plus one OTM sample (S=0x00030000) -> results identical to REQ-030, and ready_out deasserts after the 2nd acceptance.
REQ-032 Bench: n_paths=0 -> valid_out=1 within 2 cycles of start with all outputs 0.
REQ-033 Bench: hold ready_in=0 for 5 cycles in EMIT -> m, r, valid_out stable every cycle; ready_in=1 -> IDLE on the next cycle.
REQ-034 Bench: ACC_W overridden to 40, 300 ITM samples with S=0x7FFF0000 -> m[4] saturates to 0x7FFFFFFFFF, ovf=1.
REQ-035 Bench: rst_n low for 1 cycle after 3 of 10 samples, then a fresh start with n_paths=1 -> results equal REQ-030, with no leftover contribution from the aborted batch.

Source files
------------

// File: rtl/fpga_cfg_pkg.sv
// Shared fixed-point configuration and the packed moment-result payload.
package fpga_cfg_pkg;

    localparam int unsigned FP_WIDTH  = 32;
    localparam int unsigned FP_QFRAC  = 16;
    localparam int unsigned ACC_WIDTH = 64;

    typedef struct packed {
        logic [0:4][ACC_WIDTH-1:0] m;
        logic [0:2][ACC_WIDTH-1:0] r;
        logic                      ovf;
    } moments_t;

endpackage

// File: rtl/lsm_moment_pipe.sv
// Two-stage fixed-point product pipeline feeding the moment accumulators.
module lsm_moment_pipe
    import fpga_cfg_pkg::*;
#(
    parameter int unsigned WIDTH = FP_WIDTH,
    parameter int unsigned QFRAC = FP_QFRAC,
    parameter int unsigned ACC_W = ACC_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] s_in,
    input  logic signed [WIDTH-1:0] y_in,
    output logic                    out_valid,
    output logic                    out_ovf,
    output logic signed [ACC_W-1:0] s,
    output logic signed [ACC_W-1:0] s2,
    output logic signed [ACC_W-1:0] s3,
    output logic signed [ACC_W-1:0] s4,
    output logic signed [ACC_W-1:0] y,
    output logic signed [ACC_W-1:0] ys,
    output logic signed [ACC_W-1:0] ys2
);

    localparam int unsigned PW = 2 * ACC_W;

    // (a*b)>>>QFRAC with the result clamped to ACC_W; MSB of the return flags a clamp.
    function automatic logic [ACC_W:0] qmul(input logic signed [ACC_W-1:0] a,
                                            input logic signed [ACC_W-1:0] b);
        logic signed [PW-1:0] full;
        logic signed [PW-1:0] sh;
        logic [PW-ACC_W:0]    hi;
        full = PW'(a) * PW'(b);
        sh   = full >>> QFRAC;
        hi   = sh[PW-1:ACC_W-1];
        if ((&hi) || !(|hi)) begin
            return {1'b0, sh[ACC_W-1:0]};
        end
        return {1'b1, sh[PW-1], {(ACC_W-1){~sh[PW-1]}}};
    endfunction

    logic                    v1;
    logic                    ovf1;
    logic signed [ACC_W-1:0] s_1, y_1, s2_1, ys_1;
    logic signed [ACC_W-1:0] sx, yx;
    logic signed [ACC_W-1:0] c_s2, c_ys, c_s3, c_s4, c_ys2;
    logic                    o_s2, o_ys, o_s3, o_s4, o_ys2;

    always_comb begin
        sx = ACC_W'(s_in);
        yx = ACC_W'(y_in);
        {o_s2, c_s2}   = qmul(sx, sx);
        {o_ys, c_ys}   = qmul(yx, sx);
        {o_s3, c_s3}   = qmul(s2_1, s_1);
        {o_s4, c_s4}   = qmul(s2_1, s2_1);
        {o_ys2, c_ys2} = qmul(ys_1, s_1);
    end

    // Stage valid bits; no backpressure, so they only shift.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            v1        <= in_valid;
            out_valid <= v1;
        end
    end

    always_ff @(posedge clk) begin
        s_1     <= sx;
        y_1     <= yx;
        s2_1    <= c_s2;
        ys_1    <= c_ys;
        ovf1    <= o_s2 | o_ys;
        s       <= s_1;
        y       <= y_1;
        s2      <= s2_1;
        ys      <= ys_1;
        s3      <= c_s3;
        s4      <= c_s4;
        ys2     <= c_ys2;
        out_ovf <= ovf1 | o_s3 | o_s4 | o_ys2;
    end

endmodule

// File: rtl/lsm_moment_accum.sv
// Accumulates regression moments of in-the-money samples for one LSM batch.
module lsm_moment_accum
    import fpga_cfg_pkg::*;
#(
    parameter int unsigned WIDTH = FP_WIDTH,
    parameter int unsigned QFRAC = FP_QFRAC,
    parameter int unsigned ACC_W = ACC_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [15:0]             n_paths,
    input  logic                    valid_in,
    output logic                    ready_out,
    input  logic signed [WIDTH-1:0] S_t,
    input  logic signed [WIDTH-1:0] Y,
    input  logic signed [WIDTH-1:0] strike,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic [0:4][ACC_W-1:0]   m,
    output logic [0:2][ACC_W-1:0]   r,
    output logic                    ovf
);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, EMIT} state_t;

    state_t      state;
    logic [15:0] remaining;
    logic [1:0]  drain_cnt;

    logic                    accept;
    logic                    itm;
    logic                    p_valid, p_ovf;
    logic signed [ACC_W-1:0] p_s, p_s2, p_s3, p_s4, p_y, p_ys, p_ys2;

    logic [0:7][ACC_W-1:0] cur, addend, nxt;
    logic [0:7]            add_ovf;

    assign accept = valid_in && ready_out;
    assign itm    = strike > S_t;

    lsm_moment_pipe #(
        .WIDTH (WIDTH),
        .QFRAC (QFRAC),
        .ACC_W (ACC_W)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (accept && itm),
        .s_in      (S_t),
        .y_in      (Y),
        .out_valid (p_valid),
        .out_ovf   (p_ovf),
        .s         (p_s),
        .s2        (p_s2),
        .s3        (p_s3),
        .s4        (p_s4),
        .y         (p_y),
        .ys        (p_ys),
        .ys2       (p_ys2)
    );

    // Signed add clamped to ACC_W; MSB of the return flags saturation.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
        logic [ACC_W:0] sum;
        sum = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            return {1'b1, sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}};
        end
        return {1'b0, sum[ACC_W-1:0]};
    endfunction

    always_comb begin
        cur     = {m[0], m[1], m[2], m[3], m[4], r[0], r[1], r[2]};
        addend  = {ACC_W'(1), p_s, p_s2, p_s3, p_s4, p_y, p_ys, p_ys2};
        nxt     = '0;
        add_ovf = '0;
        for (int i = 0; i < 8; i++) begin
            {add_ovf[i], nxt[i]} = sat_add(cur[i], addend[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            valid_out <= 1'b0;
            ready_out <= 1'b0;
            m         <= '0;
            r         <= '0;
            ovf       <= 1'b0;
            remaining <= '0;
            drain_cnt <= '0;
        end else begin
            // Pipeline retire: only ITM samples ever reach this point.
            if (p_valid) begin
                for (int k = 0; k < 5; k++) m[k] <= nxt[k];
                for (int k = 0; k < 3; k++) r[k] <= nxt[5+k];
                if ((|add_ovf) || p_ovf) ovf <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        m         <= '0;
                        r         <= '0;
                        ovf       <= 1'b0;
                        remaining <= n_paths;
                        if (n_paths == 16'd0) begin
                            state     <= EMIT;
                            valid_out <= 1'b1;
                        end else begin
                            state     <= ACCUM;
                            ready_out <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            ready_out <= 1'b0;
                            drain_cnt <= '0;
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 2'd1;
                    if (drain_cnt == 2'd2) begin
                        state     <= EMIT;
                        valid_out <= 1'b1;
                    end
                end
                EMIT: begin
                    if (ready_in) begin
                        valid_out <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsm_moment_accum.sv
// Directed bench for lsm_moment_accum: single-sample vector table plus multi-cycle sequences.
module tb_lsm_moment_accum;
    import fpga_cfg_pkg::*;

    localparam int unsigned W    = 32;
    localparam int unsigned QF   = 16;
    localparam int unsigned AW   = 64;
    localparam int unsigned AW40 = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n, start, start40, valid_in, ready_in, ready_in40;
    logic [15:0]          n_paths;
    logic signed [W-1:0]  s_t, y, strike;
    logic                 ready_out, valid_out, ovf;
    logic [0:4][AW-1:0]   m;
    logic [0:2][AW-1:0]   r;
    logic                 ready_out40, valid_out40, ovf40;
    logic [0:4][AW40-1:0] m40;
    logic [0:2][AW40-1:0] r40;

    lsm_moment_accum #(.WIDTH(W), .QFRAC(QF), .ACC_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_paths(n_paths),
        .valid_in(valid_in), .ready_out(ready_out), .S_t(s_t), .Y(y), .strike(strike),
        .valid_out(valid_out), .ready_in(ready_in), .m(m), .r(r), .ovf(ovf)
    );

    lsm_moment_accum #(.WIDTH(W), .QFRAC(QF), .ACC_W(AW40)) dut40 (
        .clk(clk), .rst_n(rst_n), .start(start40), .n_paths(n_paths),
        .valid_in(valid_in), .ready_out(ready_out40), .S_t(s_t), .Y(y), .strike(strike),
        .valid_out(valid_out40), .ready_in(ready_in40), .m(m40), .r(r40), .ovf(ovf40)
    );

    typedef struct {
        string       name;
        logic [31:0] s;
        logic [31:0] yv;
        logic [31:0] k;
        moments_t    exp;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    vec_t vecs[7];
    moments_t exp_v1, exp_sum, zero_m;

    task automatic chk(input string name, input logic [527:0] got, input logic [527:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic moments_t mk(input logic [63:0] m0, m1, m2, m3, m4,
                                    input logic [63:0] r0, r1, r2, input logic o);
        moments_t x;
        x.m[0] = m0; x.m[1] = m1; x.m[2] = m2; x.m[3] = m3; x.m[4] = m4;
        x.r[0] = r0; x.r[1] = r1; x.r[2] = r2;
        x.ovf  = o;
        return x;
    endfunction

    function automatic vec_t mkv(input string n, input logic [31:0] s, yv, k, input moments_t e);
        vec_t v;
        v.name = n; v.s = s; v.yv = yv; v.k = k; v.exp = e;
        return v;
    endfunction

    function automatic moments_t got64();
        return {m, r, ovf};
    endfunction

    task automatic do_start(input logic sel40, input logic [15:0] n);
        n_paths = n;
        if (sel40) start40 = 1'b1; else start = 1'b1;
        tick();
        start   = 1'b0;
        start40 = 1'b0;
    endtask

    task automatic send(input logic sel40, input logic [31:0] s, yv, k);
        logic rdy;
        logic done;
        done     = 1'b0;
        valid_in = 1'b1;
        s_t      = s;
        y        = yv;
        strike   = k;
        for (int i = 0; i < 20; i++) begin
            rdy = sel40 ? ready_out40 : ready_out;
            tick();
            if (rdy) begin
                done = 1'b1;
                break;
            end
        end
        valid_in = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got=not_accepted expected=accepted");
        end
    endtask

    task automatic wait_valid(input logic sel40, input int max, input string name);
        int i;
        i = 0;
        while (((sel40 ? valid_out40 : valid_out) !== 1'b1) && i < max) begin
            tick();
            i++;
        end
        chk(name, 528'(sel40 ? valid_out40 : valid_out), 528'(1'b1));
    endtask

    task automatic release_out(input logic sel40);
        if (sel40) ready_in40 = 1'b1; else ready_in = 1'b1;
        tick();
        ready_in   = 1'b0;
        ready_in40 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start40 = 1'b0; valid_in = 1'b0;
        ready_in = 1'b0; ready_in40 = 1'b0; n_paths = '0;
        s_t = '0; y = '0; strike = '0;

        zero_m  = mk(64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0);
        exp_v1  = mk(64'h1, 64'h10000, 64'h10000, 64'h10000, 64'h10000,
                     64'h8000, 64'h8000, 64'h8000, 1'b0);
        exp_sum = mk(64'h2, 64'h30000, 64'h50000, 64'h90000, 64'h110000,
                     64'h18000, 64'h28000, 64'h48000, 1'b0);

        vecs[0] = mkv("unit_itm", 32'h0001_0000, 32'h0000_8000, 32'h0002_0000, exp_v1);
        vecs[1] = mkv("s_two", 32'h0002_0000, 32'h0001_0000, 32'h0003_0000,
                      mk(64'h1, 64'h20000, 64'h40000, 64'h80000, 64'h100000,
                         64'h10000, 64'h20000, 64'h40000, 1'b0));
        vecs[2] = mkv("s_neg", 32'hFFFF_0000, 32'h0003_0000, 32'h0000_0000,
                      mk(64'h1, 64'hFFFF_FFFF_FFFF_0000, 64'h10000, 64'hFFFF_FFFF_FFFF_0000, 64'h10000,
                         64'h30000, 64'hFFFF_FFFF_FFFD_0000, 64'h30000, 1'b0));
        vecs[3] = mkv("otm", 32'h0003_0000, 32'h0000_8000, 32'h0002_0000, zero_m);
        vecs[4] = mkv("atm_equal", 32'h0001_0000, 32'h0000_8000, 32'h0001_0000, zero_m);
        vecs[5] = mkv("trunc_pos", 32'h0000_0001, 32'h0001_0000, 32'h0001_0000,
                      mk(64'h1, 64'h1, 64'h0, 64'h0, 64'h0, 64'h10000, 64'h1, 64'h0, 1'b0));
        vecs[6] = mkv("trunc_neg", 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_0000,
                      mk(64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 64'h0,
                         64'h10000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0));

        tick();
        tick();
        chk("reset_outputs", 528'({ready_out, valid_out, got64()}), 528'({1'b0, 1'b0, zero_m}));
        rst_n = 1'b1;
        tick();
        chk("idle_after_reset", 528'({ready_out, valid_out}), 528'(2'b00));

        // Single-sample batches
        foreach (vecs[i]) begin
            do_start(1'b0, 16'd1);
            send(1'b0, vecs[i].s, vecs[i].yv, vecs[i].k);
            wait_valid(1'b0, 10, {vecs[i].name, "_valid"});
            chk(vecs[i].name, 528'(got64()), 528'(vecs[i].exp));
            release_out(1'b0);
        end

        // Two ITM samples with a gap: pins the three-cycle accumulate latency
        do_start(1'b0, 16'd2);
        send(1'b0, 32'h0001_0000, 32'h0000_8000, 32'h0002_0000);
        chk("lat_edge0", 528'(m[0]), 528'(64'h0));
        tick();
        chk("lat_edge1", 528'(m[0]), 528'(64'h0));
        tick();
        chk("lat_edge2", 528'(m[0]), 528'(64'h1));
        tick();
        send(1'b0, 32'h0002_0000, 32'h0001_0000, 32'h0003_0000);
        wait_valid(1'b0, 10, "sum_valid");
        chk("sum_two", 528'(got64()), 528'(exp_sum));
        release_out(1'b0);

        // ITM + OTM, with a start pulse mid-batch that must be ignored
        do_start(1'b0, 16'd2);
        send(1'b0, 32'h0001_0000, 32'h0000_8000, 32'h0002_0000);
        do_start(1'b0, 16'd0);
        send(1'b0, 32'h0003_0000, 32'h0000_8000, 32'h0002_0000);
        chk("ready_drop", 528'(ready_out), 528'(1'b0));
        wait_valid(1'b0, 10, "mixed_valid");
        chk("mixed_result", 528'(got64()), 528'(exp_v1));

        // Hold off the consumer for five cycles
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("emit_hold%0d", c), 528'({valid_out, got64()}), 528'({1'b1, exp_v1}));
        end
        release_out(1'b0);
        chk("emit_release", 528'(valid_out), 528'(1'b0));
        tick();
        chk("idle_hold", 528'({valid_out, got64()}), 528'({1'b0, exp_v1}));

        // Empty batch
        do_start(1'b0, 16'd0);
        wait_valid(1'b0, 1, "empty_valid");
        chk("empty_result", 528'(got64()), 528'(zero_m));
        release_out(1'b0);

        // Saturation on the narrow-accumulator instance
        do_start(1'b1, 16'd300);
        for (int i = 0; i < 300; i++) begin
            send(1'b1, 32'h7FFF_0000, 32'h0, 32'h7FFF_FFFF);
        end
        wait_valid(1'b1, 10, "sat_valid");
        chk("sat_m4", 528'(m40[4]), 528'(40'h7F_FFFF_FFFF));
        chk("sat_m0", 528'(m40[0]), 528'(40'd300));
        chk("sat_ovf", 528'(ovf40), 528'(1'b1));
        release_out(1'b1);

        // Reset mid-batch, then a clean one-sample batch
        do_start(1'b0, 16'd10);
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 32'h0002_0000, 32'h0001_0000, 32'h0003_0000);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_reset", 528'({ready_out, valid_out, got64()}), 528'({1'b0, 1'b0, zero_m}));
        do_start(1'b0, 16'd1);
        send(1'b0, 32'h0001_0000, 32'h0000_8000, 32'h0002_0000);
        wait_valid(1'b0, 10, "fresh_valid");
        chk("fresh_result", 528'(got64()), 528'(exp_v1));
        release_out(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
